bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Two-digit multiplexed seven-segment driver placed directly downstream of the BCD multiplier stage. It captures the 8-bit packed BCD product and its error flag on a load strobe, then time-multiplexes the units and tens digits onto a shared segment bus. Gap cycles between digits suppress ghosting. An error is shown as a blinking "Er".

## Interface
- CLK_DIV, 1000: clock cycles each digit is lit per scan slot (≥2)
- BLINK_DIV, 256: scan frames per blink half-period in error display (≥1)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  capture strobe for bcd_in/error_in, sampled every rising edge
- bcd_in  in  8  packed BCD; [7:4] tens, [3:0] units
- error_in  in  1  upstream error flag
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
- an  out  2  one-hot digit enable, active-high, registered; an[0]=units, an[1]=tens

## Operation
- pending register {err,tens,units} written on every cycle with load=1.
- display register copies pending on the S_GAP_T→S_UNITS transition. If load=1 in that same cycle, display takes bcd_in/error_in directly (bypass).
- FSM states: S_UNITS → S_GAP_U → S_TENS → S_GAP_T → S_UNITS.
- S_UNITS/S_TENS last CLK_DIV cycles, counted by a prescaler 0..CLK_DIV-1. Each gap state lasts exactly 1 cycle.
- In gap states: an=2'b00, seg=0.
- Digit decode (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any nibble >9: dash 40.
- Error display (display.err=1): tens shows E=79, units shows r=50, each ANDed with blink phase.
  - blink phase toggles when the frame counter (0..BLINK_DIV-1, incremented at each S_GAP_T→S_UNITS) wraps.
  - When display.err goes 0→1, the frame counter clears and phase is set to visible.
  - When err=0, the frame counter is held at 0 and phase stays visible.
- Reset (async, reset_n=0):
  - state=S_GAP_T, prescaler=0, frame counter=0, phase=visible.
  - pending=display=0.
  - seg=7'h00, an=2'b00.

## Timing
- seg/an change only on the clock edge entering a state; no combinational path from inputs to outputs.
- Frame length is 2·CLK_DIV+2 cycles.
- First edge after reset release enters S_UNITS.
- Load-to-visible latency runs from 1 cycle (load coincident with S_GAP_T) up to one frame plus 1 cycle. No value change inside a frame.
- Back-to-back loads within one frame: the last one wins.
- reset_n asserted mid-digit blanks the outputs immediately (asynchronous). Scan restarts from S_GAP_T.

## Configuration
- LEADING_ZERO_BLANK_EN defined: when err=0 and tens nibble is 0, the tens slot drives seg=0. an[1] still pulses, keeping frame timing identical.
- Undefined: the tens digit 0 is displayed as 3F.
- Error display is unaffected by this macro.

## Structure
- Package bcd_display_pkg holds:
  - the state enum (S_UNITS, S_GAP_U, S_TENS, S_GAP_T)
  - segment constants SEG_E, SEG_R, SEG_DASH, SEG_BLANK
  - the digit pattern constants 0–9
- One sub-module, bcd_to_7seg: purely combinational 4-bit nibble to 7-bit pattern, dash for >9. It is instantiated once and fed by a state-selected nibble mux.

## Test plan
Bench uses CLK_DIV=4, BLINK_DIV=2.
- Reset then idle:
  - an sequence 01×4, 00, 10×4, 00 repeats.
  - units seg=3F.
  - tens seg=3F without the macro, 00 with it.
- load bcd_in=8'h81, error_in=0 → next frame: units seg=06, tens seg=7F. Frame period is 10 cycles.
- load error_in=1 →
  - frames 1–2: tens=79, units=50.
  - frames 3–4: both 00.
  - frames 5–6: visible again.
- bcd_in=8'h0C, error_in=0 → units 40 (dash); tens 00 with the macro, 3F without.
- Loads of 8'h12 then 8'h34 inside one frame → next frame shows only 34. Load in the S_GAP_T cycle → visible in the very next S_UNITS.
- reset_n pulsed low during S_TENS → seg=00, an=00 asynchronously, pending cleared. After release, the scan resumes in S_UNITS.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared types and segment patterns for the two-digit BCD scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP_U = 2'd1,
    S_TENS  = 2'd2,
    S_GAP_T = 2'd3
  } state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] tens;
    logic [3:0] units;
  } disp_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to seven-segment pattern; non-decimal nibbles
// show a dash so a corrupted product is visible rather than misleading.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Nibble lookup
  always_comb begin
    pattern = SEG_DASH;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment driver with blanking gaps and blinking "Er".
// Optional macro LEADING_ZERO_BLANK_EN blanks a leading zero in the tens slot.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 1000,
  parameter int unsigned BLINK_DIV = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] bcd_in,
  input  logic       error_in,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [FW-1:0] FRAME_ZERO = {FW{1'b0}};

  state_t        state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [FW-1:0] frame_r, frame_s;
  logic          phase_r, phase_s;
  disp_t         pending_r, display_r, display_s;
  logic [6:0]    seg_r, seg_s;
  logic [1:0]    an_r, an_s;
  logic          frame_start_s;
  logic [3:0]    nibble_s;
  logic [6:0]    digit_s;

  // Scan sequencing: digit slots timed by the prescaler, gaps last one cycle
  always_comb begin
    state_s       = state_r;
    presc_s       = presc_r;
    frame_start_s = 1'b0;
    case (state_r)
      S_UNITS: begin
        if (presc_r == PRESC_LAST) begin
          state_s = S_GAP_U;
          presc_s = PRESC_ZERO;
        end else begin
          presc_s = presc_r + PW'(1'b1);
        end
      end
      S_GAP_U: begin
        state_s = S_TENS;
        presc_s = PRESC_ZERO;
      end
      S_TENS: begin
        if (presc_r == PRESC_LAST) begin
          state_s = S_GAP_T;
          presc_s = PRESC_ZERO;
        end else begin
          presc_s = presc_r + PW'(1'b1);
        end
      end
      S_GAP_T: begin
        state_s       = S_UNITS;
        presc_s       = PRESC_ZERO;
        frame_start_s = 1'b1;
      end
      default: begin
        state_s = S_GAP_T;
        presc_s = PRESC_ZERO;
      end
    endcase
  end

  // Frame-boundary update of the shown value and blink phase (a fresh error restarts visible)
  always_comb begin
    display_s = display_r;
    frame_s   = frame_r;
    phase_s   = phase_r;
    if (frame_start_s) begin
      if (load) begin
        display_s = {error_in, bcd_in};
      end else begin
        display_s = pending_r;
      end
      if (!display_s.err || !display_r.err) begin
        frame_s = FRAME_ZERO;
        phase_s = 1'b1;
      end else if (frame_r == FRAME_LAST) begin
        frame_s = FRAME_ZERO;
        phase_s = ~phase_r;
      end else begin
        frame_s = frame_r + FW'(1'b1);
      end
    end else begin
      display_s = display_r;
    end
  end

  assign nibble_s = (state_s == S_TENS) ? display_s.tens : display_s.units;

  bcd_to_7seg u_dec (
    .nibble  (nibble_s),
    .pattern (digit_s)
  );

  // Output pattern for the state being entered, so seg/an update on that edge
  always_comb begin
    seg_s = SEG_BLANK;
    an_s  = 2'b00;
    case (state_s)
      S_UNITS: begin
        an_s = 2'b01;
        if (display_s.err) begin
          seg_s = phase_s ? SEG_R : SEG_BLANK;
        end else begin
          seg_s = digit_s;
        end
      end
      S_TENS: begin
        an_s = 2'b10;
        if (display_s.err) begin
          seg_s = phase_s ? SEG_E : SEG_BLANK;
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
          if (display_s.tens == 4'd0) begin
            seg_s = SEG_BLANK;
          end else begin
            seg_s = digit_s;
          end
`else
          seg_s = digit_s;
`endif
        end
      end
      S_GAP_U, S_GAP_T: begin
        seg_s = SEG_BLANK;
        an_s  = 2'b00;
      end
      default: begin
        seg_s = SEG_BLANK;
        an_s  = 2'b00;
      end
    endcase
  end

  // State, counters, captured values and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_GAP_T;
      presc_r   <= PRESC_ZERO;
      frame_r   <= FRAME_ZERO;
      phase_r   <= 1'b1;
      pending_r <= 9'h000;
      display_r <= 9'h000;
      seg_r     <= SEG_BLANK;
      an_r      <= 2'b00;
    end else begin
      state_r   <= state_s;
      presc_r   <= presc_s;
      frame_r   <= frame_s;
      phase_r   <= phase_s;
      display_r <= display_s;
      seg_r     <= seg_s;
      an_r      <= an_s;
      if (load) begin
        pending_r <= {error_in, bcd_in};
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign seg = seg_r;
  assign an  = an_r;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with CLK_DIV=4, BLINK_DIV=2 (frame = 10 cycles).
module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] bcd_in;
  logic       error_in;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;

  int         ld_a_i, ld_b_i;
  logic [8:0] ld_a_v, ld_b_v;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] T0 = 7'h00;
`else
  localparam logic [6:0] T0 = 7'h3F;
`endif

  bcd_display_scan #(.CLK_DIV(4), .BLINK_DIV(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .bcd_in   (bcd_in),
    .error_in (error_in),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int pos, input logic [8:0] exp);
    checks++;
    assert ({an, seg} === exp) else begin
      errors++;
      $error("FAIL %s pos=%0d observed an=%b seg=%h expected an=%b seg=%h",
             tag, pos, an, seg, exp[8:7], exp[6:0]);
    end
  endtask

  // Entered on a negedge while in S_GAP_T; step i samples the negedge after posedge i.
  task automatic run_frame(input string tag, input logic [6:0] u, input logic [6:0] t,
                           input int nsteps);
    logic [8:0] exp;
    for (int i = 1; i <= nsteps; i++) begin
      if (i == ld_a_i) begin
        load = 1'b1;
        {error_in, bcd_in} = ld_a_v;
      end else if (i == ld_b_i) begin
        load = 1'b1;
        {error_in, bcd_in} = ld_b_v;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      case (i)
        1, 2, 3, 4: exp = {2'b01, u};
        6, 7, 8, 9: exp = {2'b10, t};
        default:    exp = 9'h000;
      endcase
      chk(tag, i, exp);
    end
    load   = 1'b0;
    ld_a_i = 0;
    ld_b_i = 0;
  endtask

  initial begin
    reset_n  = 1'b0;
    load     = 1'b0;
    bcd_in   = 8'h00;
    error_in = 1'b0;
    ld_a_i   = 0;
    ld_b_i   = 0;
    ld_a_v   = 9'h000;
    ld_b_v   = 9'h000;

    #12;
    chk("reset", 0, 9'h000);
    @(negedge clk);
    reset_n = 1'b1;

    run_frame("idle1", 7'h3F, T0, 10);
    ld_a_i = 3; ld_a_v = {1'b0, 8'h81};
    run_frame("idle2", 7'h3F, T0, 10);
    ld_a_i = 5; ld_a_v = {1'b1, 8'h81};
    run_frame("val81", 7'h06, 7'h7F, 10);

    run_frame("err_f1", 7'h50, 7'h79, 10);
    run_frame("err_f2", 7'h50, 7'h79, 10);
    run_frame("err_f3", 7'h00, 7'h00, 10);
    run_frame("err_f4", 7'h00, 7'h00, 10);
    run_frame("err_f5", 7'h50, 7'h79, 10);
    ld_a_i = 4; ld_a_v = {1'b0, 8'h0C};
    run_frame("err_f6", 7'h50, 7'h79, 10);

    ld_a_i = 2; ld_a_v = {1'b0, 8'h12};
    ld_b_i = 7; ld_b_v = {1'b0, 8'h34};
    run_frame("dash", 7'h40, T0, 10);
    run_frame("last_wins", 7'h66, 7'h4F, 10);

    ld_a_i = 1; ld_a_v = {1'b0, 8'h56};
    run_frame("bypass", 7'h7D, 7'h6D, 10);

    ld_a_i = 3; ld_a_v = {1'b0, 8'h27};
    run_frame("pre_reset", 7'h7D, 7'h6D, 7);
    #1 reset_n = 1'b0;
    #1 chk("async_reset", 7, 9'h000);
    @(negedge clk);
    chk("reset_held", 0, 9'h000);
    reset_n = 1'b1;
    run_frame("after_reset", 7'h3F, T0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
